flow_result_table: RTL and testbench
====================================

Name: flow_result_table

Overview:
Reader end of the per-flow rate pipeline. It absorbs the result stream (valid, id, send_r, send_f, derta_ack) produced by the tx/rx RAM update stage and keeps the latest result per flow in a 1024-entry table, with a saturating per-flow update count. The host reads the table through a random-access read port and a back-pressured sequential dump stream. The table auto-clears after reset and clears on command.

Parameters:
C_ID_WIDTH, 23, flow id width
C_ADDR_WIDTH, 10, table index width (index = id[9:0]); depth = 2**C_ADDR_WIDTH
C_DATA_WIDTH, 32, width of send_r, send_f and derta_ack
C_CNT_WIDTH, 16, per-entry update counter width
C_FIFO_DEPTH_BITS, 4, input buffer depth = 16

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_math_valid  in  1  result strobe, no back-pressure
in_data_id  in  23  flow id
in_send_r / in_send_f  in  32 each  divider quotient / fraction
in_derta_ack  in  32  unacked sequence delta
host_rd_req  in  1  single-cycle read request
host_rd_addr  in  10  read index
host_rd_valid  out  1  read data strobe
host_rd_hit  out  1  entry valid bit
host_rd_id  out  23
host_rd_send_r / host_rd_send_f / host_rd_derta_ack  out  32 each
host_rd_count  out  16
dump_start  in  1  start a full-table dump
dump_valid  out  1
dump_ready  in  1
dump_addr  out  10
dump_hit / dump_id / dump_send_r / dump_send_f / dump_derta_ack / dump_count  out  same widths as host_rd_*
dump_busy  out  1
clear_start  in  1  start table clear
clear_busy  out  1
drop_cnt  out  16  records dropped on full input buffer, saturating
collision_cnt  out  16  updates that replaced a different id, saturating

Behaviour:
- Entry is 136 bits: {hit 1, id 23, count 16, send_r 32, send_f 32, ack 32}. Dual-port RAM, 1-cycle read latency, read-first on same-address collision. Port A is owned by the update/clear engine. Port B is owned by host read and dump.
- Reset: all outputs 0 and all FSMs idle. clear_busy goes to 1 in the cycle after reset deasserts, and the auto-clear runs. RAM contents are not reset directly; the clear makes them defined. A reset mid-operation aborts everything, and the auto-clear runs again.
- Input: in_math_valid writes {id, send_r, send_f, ack} into the fifofall buffer. When the buffer is full, the record is dropped and drop_cnt increments, saturating at 0xFFFF.
- Update FSM, 4 cycles per record:
  - U_IDLE: when the buffer is not empty and no clear is running, drive port A address = id[9:0] and go to U_READ.
  - U_READ: go to U_WAIT.
  - U_WAIT: pop the buffer and go to U_WRITE.
  - U_WRITE: write {1, id, cnt', r, f, ack} and go to U_IDLE.
  - cnt' = 1 if the stored hit=0 or the stored id differs (collision_cnt++ when hit=1 and the id differs). Otherwise cnt' = count+1, saturating at 0xFFFF.
- Clear FSM: only starts when the update FSM is in U_IDLE. It writes all-zero entries to addresses 0..1023, one per cycle, so clear_busy is high for 1024 cycles. clear_start while clear_busy is ignored. Records arriving during a clear are buffered, and dropped once the buffer is full.
- Host read: always accepted. host_rd_valid = 1 exactly 2 cycles after host_rd_req (register the request, then the RAM read), and the data is held for that one cycle only. Reads issued during a clear return whatever is present at the read cycle.
- Dump FSM:
  - D_IDLE: dump_start → addr = 0, dump_busy = 1, go to D_RD. dump_start while busy is ignored.
  - D_RD: issue the port B read when host_rd_req is not present (host wins, dump stalls one cycle), then go to D_WAIT.
  - D_WAIT: go to D_OUT.
  - D_OUT: dump_valid = 1. Outputs are held stable until dump_ready. On accept: if addr = 1023, go to D_IDLE and drop dump_busy in the next cycle. Otherwise increment addr and go to D_RD.
  - Every one of the 1024 entries is emitted, including hit=0 entries.
- A dump and an update at the same address in the same cycle return the old data (read-first).

Decomposition:
- Shared package flow_speed_pkg:
  - entry field offsets and widths (hit, id, count, send_r, send_f, ack) and ENTRY_W = 136
  - TABLE_DEPTH
  - U_*/D_* state encodings
  - saturating-counter max value
- One sub-module, flow_result_ram: a simple dual-port 136x1024 RAM with 1-cycle read latency and read-first behaviour.
- The input buffer reuses the existing fifofall.

Test Plan:
1. Reset → clear_busy is high for 1024 cycles. Then host_rd_addr=5 → host_rd_valid 2 cycles later with hit=0 and every field 0.
2. Records id=0x000005 (r=0x10, f=0x20, ack=3), then id=0x000005 (r=0x11, f=0x21, ack=4) → read addr 5 returns hit=1, id=5, count=2, r=0x11, f=0x21, ack=4.
3. id=0x000405 after step 2 (same index 5) → id=0x405, count=1, collision_cnt=1.
4. 20 back-to-back records during a clear → 16 are buffered and applied after the clear, and drop_cnt=4.
5. dump_start with dump_ready toggling 1/0 → exactly 1024 beats, addr 0..1023 in order. Data is stable while ready=0, and dump_busy drops after beat 1023. A host_rd_req mid-dump still returns on time.
6. 0x10000 updates to one id → count saturates at 0xFFFF.

Source files
------------

// File: rtl/flow_speed_pkg.sv
// Shared types and layout constants for the per-flow result table.
// Entry layout is {hit, id, count, send_r, send_f, ack}, MSB first.
package flow_speed_pkg;

  localparam int ID_W   = 23;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int FIFO_DEPTH_BITS = 4;

  localparam int ACK_LSB = 0;
  localparam int F_LSB   = ACK_LSB + DATA_W;
  localparam int R_LSB   = F_LSB + DATA_W;
  localparam int CNT_LSB = R_LSB + DATA_W;
  localparam int ID_LSB  = CNT_LSB + CNT_W;
  localparam int HIT_BIT = ID_LSB + ID_W;
  localparam int ENTRY_W = HIT_BIT + 1;

  localparam int TABLE_DEPTH = 2 ** ADDR_W;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    U_IDLE,
    U_READ,
    U_WAIT,
    U_WRITE
  } upd_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RD,
    D_WAIT,
    D_OUT
  } dump_state_e;

endpackage

// File: rtl/flow_result_table_if.sv
// Back-pressured sequential dump stream of the flow result table.
interface flow_result_table_if #(
  parameter int ADDR_W = 10,
  parameter int ID_W   = 23,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_hit;
  logic [ID_W-1:0]   dump_id;
  logic [DATA_W-1:0] dump_send_r;
  logic [DATA_W-1:0] dump_send_f;
  logic [DATA_W-1:0] dump_derta_ack;
  logic [CNT_W-1:0]  dump_count;
  logic              dump_busy;

  modport master (
    output dump_valid, dump_addr, dump_hit, dump_id, dump_send_r,
           dump_send_f, dump_derta_ack, dump_count, dump_busy,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_addr, dump_hit, dump_id, dump_send_r,
           dump_send_f, dump_derta_ack, dump_count, dump_busy,
    output dump_ready
  );
endinterface

// File: rtl/fifofall.sv
// Show-ahead synchronous FIFO; writes while full are discarded.
module fifofall #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]    mem [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                wr_ok, rd_ok;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
            (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + (DEPTH_BITS+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + (DEPTH_BITS+1)'(1) : rd_ptr_q;
    dout = mem[rd_ptr_q[DEPTH_BITS-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[DEPTH_BITS-1:0]] <= din;
  end
endmodule

// File: rtl/flow_result_ram.sv
// Simple dual-port RAM: port A read/write, port B read-only.
// Registered reads, read-first on a same-address write.
module flow_result_ram #(
  parameter int WIDTH  = 136,
  parameter int ADDR_W = 10
)(
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/flow_result_table.sv
// Keeps the latest rate result per flow with a saturating update count;
// host random reads and a sequential dump share RAM port B.
module flow_result_table
  import flow_speed_pkg::*;
#(
  parameter int C_ID_WIDTH        = ID_W,
  parameter int C_ADDR_WIDTH      = ADDR_W,
  parameter int C_DATA_WIDTH      = DATA_W,
  parameter int C_CNT_WIDTH       = CNT_W,
  parameter int C_FIFO_DEPTH_BITS = FIFO_DEPTH_BITS
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_math_valid,
  input  logic [C_ID_WIDTH-1:0]   in_data_id,
  input  logic [C_DATA_WIDTH-1:0] in_send_r,
  input  logic [C_DATA_WIDTH-1:0] in_send_f,
  input  logic [C_DATA_WIDTH-1:0] in_derta_ack,
  input  logic                    host_rd_req,
  input  logic [C_ADDR_WIDTH-1:0] host_rd_addr,
  output logic                    host_rd_valid,
  output logic                    host_rd_hit,
  output logic [C_ID_WIDTH-1:0]   host_rd_id,
  output logic [C_DATA_WIDTH-1:0] host_rd_send_r,
  output logic [C_DATA_WIDTH-1:0] host_rd_send_f,
  output logic [C_DATA_WIDTH-1:0] host_rd_derta_ack,
  output logic [C_CNT_WIDTH-1:0]  host_rd_count,
  input  logic                    dump_start,
  flow_result_table_if.master     dump,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             collision_cnt
);
  localparam int DW      = C_DATA_WIDTH;
  localparam int REC_W   = C_ID_WIDTH + 3 * DW;
  localparam int CNT_LSB = 3 * DW;
  localparam int ID_LSB  = CNT_LSB + C_CNT_WIDTH;
  localparam int HIT_BIT = ID_LSB + C_ID_WIDTH;
  localparam int EW      = HIT_BIT + 1;
  localparam logic [C_CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [C_CNT_WIDTH-1:0]  CNT_ONE   = C_CNT_WIDTH'(1);
  localparam logic [C_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [REC_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, fifo_rd;

  logic [C_ADDR_WIDTH-1:0] a_addr, b_addr;
  logic                    a_we;
  logic [EW-1:0]           a_wdata, a_rdata, b_rdata;

  upd_state_e              upd_state_q, upd_state_d;
  logic [REC_W-1:0]        rec_q, rec_d;
  logic                    old_hit_q, old_hit_d;
  logic [C_ID_WIDTH-1:0]   old_id_q, old_id_d;
  logic [C_CNT_WIDTH-1:0]  old_cnt_q, old_cnt_d;
  logic                    clr_busy_q, clr_busy_d;
  logic                    clr_pend_q, clr_pend_d;
  logic [C_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [15:0]             coll_cnt_q, coll_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    host_valid_q, host_valid_d;
  logic [EW-1:0]           host_entry_q, host_entry_d;
  dump_state_e             dump_state_q, dump_state_d;
  logic [C_ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic                    dump_busy_q, dump_busy_d;
  logic                    dump_valid_q, dump_valid_d;
  logic [EW-1:0]           dump_entry_q, dump_entry_d;

  logic [C_ID_WIDTH-1:0]  head_id, rec_id;
  logic [C_CNT_WIDTH-1:0] new_cnt;
  logic                   clr_go, upd_go, same_flow;
  logic                   unused_a_payload;

  fifofall #(
    .WIDTH      (REC_W),
    .DEPTH_BITS (C_FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (in_math_valid),
    .din   ({in_data_id, in_send_r, in_send_f, in_derta_ack}),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  flow_result_ram #(
    .WIDTH  (EW),
    .ADDR_W (C_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_rdata (b_rdata)
  );

  assign unused_a_payload = ^a_rdata[CNT_LSB-1:0];

  always_comb begin
    upd_state_d  = upd_state_q;
    rec_d        = rec_q;
    old_hit_d    = old_hit_q;
    old_id_d     = old_id_q;
    old_cnt_d    = old_cnt_q;
    clr_busy_d   = clr_busy_q;
    clr_pend_d   = clr_pend_q;
    clr_addr_d   = clr_addr_q;
    drop_cnt_d   = drop_cnt_q;
    coll_cnt_d   = coll_cnt_q;
    dump_state_d = dump_state_q;
    dump_addr_d  = dump_addr_q;
    dump_busy_d  = dump_busy_q;
    dump_valid_d = dump_valid_q;
    dump_entry_d = dump_entry_q;

    head_id   = fifo_dout[REC_W-1 -: C_ID_WIDTH];
    rec_id    = rec_q[REC_W-1 -: C_ID_WIDTH];
    fifo_rd   = (upd_state_q == U_WAIT);
    clr_go    = (clr_pend_q || clear_start) && !clr_busy_q && (upd_state_q == U_IDLE);
    upd_go    = (upd_state_q == U_IDLE) && !fifo_empty && !clr_busy_q && !clr_go;
    same_flow = old_hit_q && (old_id_q == rec_id);
    if (!same_flow)              new_cnt = CNT_ONE;
    else if (old_cnt_q == CNT_MAX) new_cnt = CNT_MAX;
    else                         new_cnt = old_cnt_q + CNT_ONE;

    a_we    = 1'b0;
    a_addr  = head_id[C_ADDR_WIDTH-1:0];
    a_wdata = '0;

    // Clear and update never overlap on port A: clear only launches from U_IDLE
    // and the update FSM will not leave U_IDLE while a clear is running.
    if (clr_busy_q) begin
      a_we       = 1'b1;
      a_addr     = clr_addr_q;
      clr_addr_d = clr_addr_q + C_ADDR_WIDTH'(1);
      if (clr_addr_q == LAST_ADDR) clr_busy_d = 1'b0;
    end else if (clr_go) begin
      clr_busy_d = 1'b1;
      clr_pend_d = 1'b0;
      clr_addr_d = '0;
    end else if (clear_start) begin
      clr_pend_d = 1'b1;
    end

    unique case (upd_state_q)
      U_IDLE: begin
        if (upd_go) begin
          rec_d       = fifo_dout;
          upd_state_d = U_READ;
        end
      end
      U_READ: begin
        old_hit_d   = a_rdata[HIT_BIT];
        old_id_d    = a_rdata[ID_LSB +: C_ID_WIDTH];
        old_cnt_d   = a_rdata[CNT_LSB +: C_CNT_WIDTH];
        upd_state_d = U_WAIT;
      end
      U_WAIT: upd_state_d = U_WRITE;
      U_WRITE: begin
        a_we    = 1'b1;
        a_addr  = rec_id[C_ADDR_WIDTH-1:0];
        a_wdata = {1'b1, rec_id, new_cnt, rec_q[CNT_LSB-1:0]};
        if (old_hit_q && !same_flow && coll_cnt_q != SAT_MAX)
          coll_cnt_d = coll_cnt_q + 16'd1;
        upd_state_d = U_IDLE;
      end
      default: upd_state_d = U_IDLE;
    endcase

    if (in_math_valid && fifo_full && drop_cnt_q != SAT_MAX)
      drop_cnt_d = drop_cnt_q + 16'd1;

    rd_pend_d    = host_rd_req;
    host_valid_d = rd_pend_q;
    host_entry_d = rd_pend_q ? b_rdata : '0;
    b_addr       = host_rd_req ? host_rd_addr : dump_addr_q;

    unique case (dump_state_q)
      D_IDLE: begin
        if (dump_start) begin
          dump_addr_d  = '0;
          dump_busy_d  = 1'b1;
          dump_state_d = D_RD;
        end
      end
      D_RD: if (!host_rd_req) dump_state_d = D_WAIT;
      D_WAIT: begin
        dump_entry_d = b_rdata;
        dump_valid_d = 1'b1;
        dump_state_d = D_OUT;
      end
      D_OUT: begin
        if (dump.dump_ready) begin
          dump_valid_d = 1'b0;
          if (dump_addr_q == LAST_ADDR) begin
            dump_busy_d  = 1'b0;
            dump_state_d = D_IDLE;
          end else begin
            dump_addr_d  = dump_addr_q + C_ADDR_WIDTH'(1);
            dump_state_d = D_RD;
          end
        end
      end
      default: dump_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_state_q  <= U_IDLE;
      rec_q        <= '0;
      old_hit_q    <= 1'b0;
      old_id_q     <= '0;
      old_cnt_q    <= '0;
      clr_busy_q   <= 1'b0;
      clr_pend_q   <= 1'b1;
      clr_addr_q   <= '0;
      drop_cnt_q   <= '0;
      coll_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      host_valid_q <= 1'b0;
      host_entry_q <= '0;
      dump_state_q <= D_IDLE;
      dump_addr_q  <= '0;
      dump_busy_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_entry_q <= '0;
    end else begin
      upd_state_q  <= upd_state_d;
      rec_q        <= rec_d;
      old_hit_q    <= old_hit_d;
      old_id_q     <= old_id_d;
      old_cnt_q    <= old_cnt_d;
      clr_busy_q   <= clr_busy_d;
      clr_pend_q   <= clr_pend_d;
      clr_addr_q   <= clr_addr_d;
      drop_cnt_q   <= drop_cnt_d;
      coll_cnt_q   <= coll_cnt_d;
      rd_pend_q    <= rd_pend_d;
      host_valid_q <= host_valid_d;
      host_entry_q <= host_entry_d;
      dump_state_q <= dump_state_d;
      dump_addr_q  <= dump_addr_d;
      dump_busy_q  <= dump_busy_d;
      dump_valid_q <= dump_valid_d;
      dump_entry_q <= dump_entry_d;
    end
  end

  assign host_rd_valid     = host_valid_q;
  assign host_rd_hit       = host_entry_q[HIT_BIT];
  assign host_rd_id        = host_entry_q[ID_LSB +: C_ID_WIDTH];
  assign host_rd_count     = host_entry_q[CNT_LSB +: C_CNT_WIDTH];
  assign host_rd_send_r    = host_entry_q[2*DW +: DW];
  assign host_rd_send_f    = host_entry_q[DW +: DW];
  assign host_rd_derta_ack = host_entry_q[0 +: DW];

  assign dump.dump_valid     = dump_valid_q;
  assign dump.dump_addr      = dump_addr_q;
  assign dump.dump_busy      = dump_busy_q;
  assign dump.dump_hit       = dump_entry_q[HIT_BIT];
  assign dump.dump_id        = dump_entry_q[ID_LSB +: C_ID_WIDTH];
  assign dump.dump_count     = dump_entry_q[CNT_LSB +: C_CNT_WIDTH];
  assign dump.dump_send_r    = dump_entry_q[2*DW +: DW];
  assign dump.dump_send_f    = dump_entry_q[DW +: DW];
  assign dump.dump_derta_ack = dump_entry_q[0 +: DW];

  assign clear_busy    = clr_busy_q;
  assign drop_cnt      = drop_cnt_q;
  assign collision_cnt = coll_cnt_q;
endmodule

// File: tb/tb_flow_result_table.sv
// Scoreboard bench for flow_result_table; count width narrowed to 4 so
// saturation is reachable in a short run.
module tb_flow_result_table;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_math_valid;
  logic [22:0] in_data_id;
  logic [31:0] in_send_r, in_send_f, in_derta_ack;
  logic        host_rd_req;
  logic [9:0]  host_rd_addr;
  logic        host_rd_valid, host_rd_hit;
  logic [22:0] host_rd_id;
  logic [31:0] host_rd_send_r, host_rd_send_f, host_rd_derta_ack;
  logic [CW-1:0] host_rd_count;
  logic        dump_start, clear_start, clear_busy;
  logic [15:0] drop_cnt, collision_cnt;

  flow_result_table_if #(.ADDR_W(10), .ID_W(23), .DATA_W(32), .CNT_W(CW)) dif ();

  flow_result_table #(.C_CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_math_valid     (in_math_valid),
    .in_data_id        (in_data_id),
    .in_send_r         (in_send_r),
    .in_send_f         (in_send_f),
    .in_derta_ack      (in_derta_ack),
    .host_rd_req       (host_rd_req),
    .host_rd_addr      (host_rd_addr),
    .host_rd_valid     (host_rd_valid),
    .host_rd_hit       (host_rd_hit),
    .host_rd_id        (host_rd_id),
    .host_rd_send_r    (host_rd_send_r),
    .host_rd_send_f    (host_rd_send_f),
    .host_rd_derta_ack (host_rd_derta_ack),
    .host_rd_count     (host_rd_count),
    .dump_start        (dump_start),
    .dump              (dif.master),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy),
    .drop_cnt          (drop_cnt),
    .collision_cnt     (collision_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference table
  logic          m_hit [1024];
  logic [22:0]   m_id  [1024];
  logic [CW-1:0] m_cnt [1024];
  logic [31:0]   m_r   [1024];
  logic [31:0]   m_f   [1024];
  logic [31:0]   m_a   [1024];
  int exp_drop = 0;
  int exp_coll = 0;

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) begin
      m_hit[i] = 1'b0; m_id[i] = '0; m_cnt[i] = '0;
      m_r[i] = '0; m_f[i] = '0; m_a[i] = '0;
    end
  endtask

  task automatic model_apply(input logic [22:0] id, input logic [31:0] r, f, a);
    int idx;
    idx = int'(id[9:0]);
    if (m_hit[idx] && m_id[idx] == id) begin
      if (m_cnt[idx] != {CW{1'b1}}) m_cnt[idx] = m_cnt[idx] + 1'b1;
    end else begin
      if (m_hit[idx]) exp_coll++;
      m_cnt[idx] = 1;
    end
    m_hit[idx] = 1'b1; m_id[idx] = id;
    m_r[idx] = r; m_f[idx] = f; m_a[idx] = a;
  endtask

  typedef struct {
    int            due;
    logic          hit;
    logic [22:0]   id;
    logic [CW-1:0] cnt;
    logic [31:0]   r, f, a;
  } rd_exp_t;
  rd_exp_t rdq[$];

  task automatic push_read(input logic [9:0] addr);
    rd_exp_t e;
    e.due = cyc + 2;
    e.hit = m_hit[addr]; e.id = m_id[addr]; e.cnt = m_cnt[addr];
    e.r = m_r[addr]; e.f = m_f[addr]; e.a = m_a[addr];
    rdq.push_back(e);
  endtask

  task automatic host_read(input logic [9:0] addr);
    @(negedge clk);
    host_rd_req = 1'b1; host_rd_addr = addr;
    push_read(addr);
    @(negedge clk);
    host_rd_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && host_rd_valid) begin
      if (rdq.size() == 0) begin
        check_val("rd_unexpected", 64'd1, 64'd0);
      end else begin
        rd_exp_t e;
        e = rdq.pop_front();
        check_val("rd_latency", 64'(cyc),          64'(e.due));
        check_val("rd_hit",     64'(host_rd_hit),  64'(e.hit));
        check_val("rd_id",      64'(host_rd_id),   64'(e.id));
        check_val("rd_count",   64'(host_rd_count), 64'(e.cnt));
        check_val("rd_send_r",  64'(host_rd_send_r), 64'(e.r));
        check_val("rd_send_f",  64'(host_rd_send_f), 64'(e.f));
        check_val("rd_ack",     64'(host_rd_derta_ack), 64'(e.a));
      end
    end
  end

  task automatic send_rec(input logic [22:0] id, input logic [31:0] r, f, a, input int gap);
    @(negedge clk);
    in_math_valid = 1'b1; in_data_id = id;
    in_send_r = r; in_send_f = f; in_derta_ack = a;
    if (gap > 0) begin
      @(negedge clk);
      in_math_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int beats;
    int waited;
    bit hr_issued;
    bit held;
    logic [9:0]  held_addr;
    logic [22:0] held_id;
    logic [31:0] held_r;

    reset = 1'b1; in_math_valid = 1'b0; in_data_id = '0;
    in_send_r = '0; in_send_f = '0; in_derta_ack = '0;
    host_rd_req = 1'b0; host_rd_addr = '0;
    dump_start = 1'b0; clear_start = 1'b0; dif.dump_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_clear_busy", 64'(clear_busy),    64'd0);
    check_val("rst_rd_valid",   64'(host_rd_valid), 64'd0);
    check_val("rst_dump_valid", 64'(dif.dump_valid), 64'd0);
    check_val("rst_dump_busy",  64'(dif.dump_busy),  64'd0);
    check_val("rst_drop",       64'(drop_cnt),      64'd0);
    check_val("rst_coll",       64'(collision_cnt), 64'd0);
    reset = 1'b0;

    // auto-clear length
    busy_cycles = 0;
    waited = 0;
    while (waited < 2000 && !(busy_cycles > 0 && !clear_busy)) begin
      @(negedge clk);
      if (clear_busy) busy_cycles++;
      waited++;
    end
    check_val("autoclear_len", 64'(busy_cycles), 64'd1024);
    model_clear();
    host_read(10'd5);

    // repeat update of one flow
    send_rec(23'h000005, 32'h10, 32'h20, 32'd3, 8);
    model_apply(23'h000005, 32'h10, 32'h20, 32'd3);
    send_rec(23'h000005, 32'h11, 32'h21, 32'd4, 8);
    model_apply(23'h000005, 32'h11, 32'h21, 32'd4);
    repeat (5) @(negedge clk);
    host_read(10'd5);

    // different id on the same index
    send_rec(23'h000405, 32'h12, 32'h22, 32'd5, 8);
    model_apply(23'h000405, 32'h12, 32'h22, 32'd5);
    repeat (5) @(negedge clk);
    host_read(10'd5);
    check_val("collision_cnt", 64'(collision_cnt), 64'(exp_coll));

    // count saturation
    for (int i = 0; i < 20; i++) begin
      send_rec(23'h000009, 32'h100 + i, 32'h200 + i, i, 5);
      model_apply(23'h000009, 32'h100 + i, 32'h200 + i, i);
    end
    repeat (10) @(negedge clk);
    host_read(10'd9);
    check_val("coll_after_sat", 64'(collision_cnt), 64'(exp_coll));

    // records arriving while a clear runs
    @(negedge clk); clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    waited = 0;
    while (!clear_busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_val("clear_started", 64'(clear_busy), 64'd1);
    model_clear();
    for (int i = 0; i < 20; i++) begin
      send_rec(23'h000100 + i, 32'h1000 + i, 32'h2000 + i, i, 0);
      if (i < 16) model_apply(23'h000100 + i, 32'h1000 + i, 32'h2000 + i, i);
      else exp_drop++;
    end
    @(negedge clk); in_math_valid = 1'b0;
    clear_start = 1'b1;
    @(negedge clk); clear_start = 1'b0;
    waited = 0;
    while (clear_busy && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_val("clear_ended", 64'(clear_busy), 64'd0);
    repeat (80) @(negedge clk);
    check_val("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    host_read(10'h100);
    host_read(10'h10F);
    host_read(10'h110);
    host_read(10'd5);
    host_read(10'd9);

    // full dump with toggling ready and one host read in the middle
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    check_val("dump_busy_on", 64'(dif.dump_busy), 64'd1);
    beats = 0; waited = 0; hr_issued = 0; held = 0;
    held_addr = '0; held_id = '0; held_r = '0;
    while (beats < 1024 && waited < 20000) begin
      if (host_rd_req) host_rd_req = 1'b0;
      if (!hr_issued && beats == 100) begin
        host_rd_req = 1'b1; host_rd_addr = 10'h101;
        push_read(10'h101);
        hr_issued = 1;
      end
      if (dif.dump_valid) begin
        if (held) begin
          check_val("dump_hold_addr", 64'(dif.dump_addr),   64'(held_addr));
          check_val("dump_hold_id",   64'(dif.dump_id),     64'(held_id));
          check_val("dump_hold_r",    64'(dif.dump_send_r), 64'(held_r));
        end
        if (dif.dump_ready) begin
          check_val("dump_addr",  64'(dif.dump_addr),      64'(beats));
          check_val("dump_hit",   64'(dif.dump_hit),       64'(m_hit[beats]));
          check_val("dump_id",    64'(dif.dump_id),        64'(m_id[beats]));
          check_val("dump_count", 64'(dif.dump_count),     64'(m_cnt[beats]));
          check_val("dump_r",     64'(dif.dump_send_r),    64'(m_r[beats]));
          check_val("dump_f",     64'(dif.dump_send_f),    64'(m_f[beats]));
          check_val("dump_ack",   64'(dif.dump_derta_ack), 64'(m_a[beats]));
          beats++;
          held = 0;
        end else begin
          held = 1;
          held_addr = dif.dump_addr; held_id = dif.dump_id; held_r = dif.dump_send_r;
        end
      end
      if (beats < 1024) begin
        @(negedge clk);
        dif.dump_ready = ~dif.dump_ready;
        waited++;
      end
    end
    host_rd_req = 1'b0;
    check_val("dump_beats", 64'(beats), 64'd1024);
    @(negedge clk);
    check_val("dump_busy_off",  64'(dif.dump_busy),  64'd0);
    check_val("dump_valid_off", 64'(dif.dump_valid), 64'd0);
    dif.dump_ready = 1'b0;
    repeat (5) @(negedge clk);

    check_val("final_drop", 64'(drop_cnt),      64'(exp_drop));
    check_val("final_coll", 64'(collision_cnt), 64'(exp_coll));
    check_val("rd_pending", 64'(rdq.size()),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
